pong_match_controller: RTL and testbench

Match sequencer for the pong table. It samples the two goal IR sensors and the start button, and debounces them on a shared sample tick. It arbitrates goal events into a single scoring path and runs the serve/rally/point/game-over sequence. It owns both players' scores and the winner flag, and feeds the score display and LED logic at the top level.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/pong_debounce.sv | 61 ++++++
 rtl/pong_match_controller.sv | 166 ++++++++++++++++
 tb/tb_pong_match_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared encodings for the pong match sequencer.
//   state_e  : FSM state encoding exported on the top-level state port
//   winner_e : winner flag codes
//   SCORE_W  : width of each player's score
package pong_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_RALLY     = 3'd2,
    ST_HOLDOFF   = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_e;

endpackage

// File: rtl/pong_debounce.sv
// pong_debounce: conditions one raw asynchronous input.
//   clk, reset_n : clock, synchronous active-low reset
//   sample_tick  : shared one-cycle sample strobe
//   raw_in       : raw asynchronous input
//   level        : debounced level (registered)
//   rise         : one-cycle strobe on the tick where the level goes 0->1
module pong_debounce #(
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic raw_in,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_SAMPLES < 2) ? 1 : $clog2(DEBOUNCE_SAMPLES + 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Count consecutive ticks that disagree with the current level; any
  // agreeing tick restarts the run.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sample_tick) begin
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_SAMPLES - 1)) begin
          level_d = sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  // Strobe lands on the tick cycle itself so the FSM can act on the next edge.
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/pong_match_controller.sv
// pong_match_controller: pong match sequencer.
//   clk_100MHz, reset_n       : clock, synchronous active-low reset
//   start_btn, ir_left/right  : raw asynchronous inputs
//   score_left, score_right   : per-player binary scores
//   state                     : FSM state (pong_pkg::state_e)
//   serve_side                : 0 left serves, 1 right serves
//   winner                    : pong_pkg::winner_e
//   point_pulse               : one-cycle strobe per scored point
// All outputs come straight from flops.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int CLK_HZ           = 100_000_000,
  parameter int SAMPLE_HZ        = 1000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int HOLDOFF_TICKS    = 500,
  parameter int WIN_SCORE        = 7
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic               start_btn,
  input  logic               ir_left,
  input  logic               ir_right,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [2:0]         state,
  output logic               serve_side,
  output logic [1:0]         winner,
  output logic               point_pulse
);

  localparam int DIV  = CLK_HZ / SAMPLE_HZ;
  localparam int PW   = $clog2(DIV);
  localparam int HW   = (HOLDOFF_TICKS < 2) ? 1 : $clog2(HOLDOFF_TICKS + 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          sample_tick;

  assign sample_tick = (presc_q == PW'(DIV - 1));
  assign presc_d     = sample_tick ? '0 : presc_q + PW'(1);

  logic [2:0] lvl, rise;

  // 0: start, 1: ir_left, 2: ir_right
  pong_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb [2:0] (
    .clk         (clk_100MHz),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .raw_in      ({ir_right, ir_left, start_btn}),
    .level       (lvl),
    .rise        (rise)
  );

  logic start_ev, goal_l_ev, goal_r_ev;
  assign start_ev  = rise[0];
  assign goal_l_ev = rise[1];
  assign goal_r_ev = rise[2];

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;
  logic               serve_q, serve_d;
  winner_e            winner_q, winner_d;
  logic               pulse_q, pulse_d;
  logic [HW-1:0]      hold_q, hold_d;

  assign score_l_inc = score_l_q + SCORE_W'(1);
  assign score_r_inc = score_r_q + SCORE_W'(1);

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    serve_d   = serve_q;
    winner_d  = winner_q;
    pulse_d   = 1'b0;
    hold_d    = hold_q;
    case (state_q)
      ST_IDLE: begin
        score_l_d = '0;
        score_r_d = '0;
        winner_d  = WIN_NONE;
        if (start_ev) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (start_ev) state_d = ST_RALLY;
      end
      ST_RALLY: begin
        hold_d = '0;
        if (goal_l_ev && goal_r_ev) begin
          // Simultaneous goals: let, replay the point.
          state_d = ST_HOLDOFF;
        end else if (goal_l_ev) begin
          score_r_d = score_r_inc;
          serve_d   = 1'b0;
          pulse_d   = 1'b1;
          if (score_r_inc == SCORE_W'(WIN_SCORE)) begin
            state_d  = ST_GAME_OVER;
            winner_d = WIN_RIGHT;
          end else begin
            state_d = ST_HOLDOFF;
          end
        end else if (goal_r_ev) begin
          score_l_d = score_l_inc;
          serve_d   = 1'b1;
          pulse_d   = 1'b1;
          if (score_l_inc == SCORE_W'(WIN_SCORE)) begin
            state_d  = ST_GAME_OVER;
            winner_d = WIN_LEFT;
          end else begin
            state_d = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        if (sample_tick) begin
          if (hold_q == HW'(HOLDOFF_TICKS - 1)) begin
            hold_d  = '0;
            state_d = ST_SERVE;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      ST_GAME_OVER: begin
        if (start_ev) begin
          state_d   = ST_IDLE;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = WIN_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      presc_q   <= '0;
      state_q   <= ST_IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
      serve_q   <= 1'b0;
      winner_q  <= WIN_NONE;
      pulse_q   <= 1'b0;
      hold_q    <= '0;
    end else begin
      presc_q   <= presc_d;
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      serve_q   <= serve_d;
      winner_q  <= winner_d;
      pulse_q   <= pulse_d;
      hold_q    <= hold_d;
    end
  end

  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign state       = state_q;
  assign serve_side  = serve_q;
  assign winner      = winner_q;
  assign point_pulse = pulse_q;

endmodule

// File: tb/tb_pong_match_controller.sv
module tb_pong_match_controller;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_RALLY = 3'd2,
                         S_HOLD = 3'd3, S_GO = 3'd4;

  logic       clk_100MHz = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_btn = 1'b0, ir_left = 1'b0, ir_right = 1'b0;
  logic [3:0] score_left, score_right;
  logic [2:0] state;
  logic       serve_side;
  logic [1:0] winner;
  logic       point_pulse;

  pong_match_controller #(
    .CLK_HZ(1000), .SAMPLE_HZ(100), .DEBOUNCE_SAMPLES(2),
    .HOLDOFF_TICKS(3), .WIN_SCORE(3)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .start_btn(start_btn),
    .ir_left(ir_left), .ir_right(ir_right), .score_left(score_left),
    .score_right(score_right), .state(state), .serve_side(serve_side),
    .winner(winner), .point_pulse(point_pulse)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard: expected output snapshot at the cycle point_pulse fires.
  typedef struct packed {
    logic [3:0] sl;
    logic [3:0] sr;
    logic       ss;
    logic [1:0] win;
    logic [2:0] st;
  } snap_t;
  snap_t sb[$];

  logic prev_pulse = 1'b0;
  always @(negedge clk_100MHz) begin
    if (point_pulse) begin
      chk("pulse_width", int'(prev_pulse), 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        snap_t e;
        e = sb.pop_front();
        chk("pt_score_left", score_left, e.sl);
        chk("pt_score_right", score_right, e.sr);
        chk("pt_serve_side", serve_side, e.ss);
        chk("pt_winner", winner, e.win);
        chk("pt_state", state, e.st);
      end
    end
    prev_pulse <= point_pulse;
  end

  typedef enum int { A_START, A_LEFT, A_RIGHT, A_BOTH, A_GLITCH_L, A_HOLD_L } act_e;

  typedef struct {
    act_e       act;
    logic [2:0] st;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       ss;
    logic [1:0] win;
    bit         scores;
  } vec_t;

  vec_t vec[18];

  task automatic press(input logic s, input logic l, input logic r,
                       input int hi, input int lo);
    @(negedge clk_100MHz);
    start_btn = s; ir_left = l; ir_right = r;
    repeat (hi) @(negedge clk_100MHz);
    start_btn = 1'b0; ir_left = 1'b0; ir_right = 1'b0;
    repeat (lo) @(negedge clk_100MHz);
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input int sl,
                            input int sr, input int ss, input int win);
    chk({tag, "_state"}, state, st);
    chk({tag, "_score_left"}, score_left, sl);
    chk({tag, "_score_right"}, score_right, sr);
    chk({tag, "_serve_side"}, serve_side, ss);
    chk({tag, "_winner"}, winner, win);
  endtask

  task automatic run_vec(input int i);
    snap_t e;
    if (vec[i].scores) begin
      e.sl = vec[i].sl; e.sr = vec[i].sr; e.ss = vec[i].ss; e.win = vec[i].win;
      e.st = (vec[i].win != 2'b00) ? S_GO : S_HOLD;
      sb.push_back(e);
    end
    case (vec[i].act)
      A_START:    press(1, 0, 0, 30, 50);
      A_LEFT:     press(0, 1, 0, 30, 50);
      A_RIGHT:    press(0, 0, 1, 30, 50);
      A_BOTH:     press(0, 1, 1, 30, 50);
      A_GLITCH_L: press(0, 1, 0, 10, 50);
      A_HOLD_L:   press(0, 1, 0, 500, 50);
      default:    ;
    endcase
    check_outs($sformatf("vec%0d", i), vec[i].st, vec[i].sl, vec[i].sr,
               vec[i].ss, vec[i].win);
  endtask

  initial begin
    vec[0]  = '{A_START,    S_SERVE, 0, 0, 0, 2'b00, 0};
    vec[1]  = '{A_START,    S_RALLY, 0, 0, 0, 2'b00, 0};
    vec[2]  = '{A_RIGHT,    S_SERVE, 1, 0, 1, 2'b00, 1};
    vec[3]  = '{A_START,    S_RALLY, 1, 0, 1, 2'b00, 0};
    vec[4]  = '{A_GLITCH_L, S_RALLY, 1, 0, 1, 2'b00, 0};
    vec[5]  = '{A_HOLD_L,   S_SERVE, 1, 1, 0, 2'b00, 1};
    vec[6]  = '{A_START,    S_RALLY, 1, 1, 0, 2'b00, 0};
    vec[7]  = '{A_BOTH,     S_SERVE, 1, 1, 0, 2'b00, 0};
    vec[8]  = '{A_START,    S_RALLY, 1, 1, 0, 2'b00, 0};
    vec[9]  = '{A_RIGHT,    S_SERVE, 2, 1, 1, 2'b00, 1};
    vec[10] = '{A_START,    S_RALLY, 2, 1, 1, 2'b00, 0};
    // after the hand-written lockout sequence: 2-2, in RALLY
    vec[11] = '{A_RIGHT,    S_GO,    3, 2, 1, 2'b01, 1};
    vec[12] = '{A_LEFT,     S_GO,    3, 2, 1, 2'b01, 0};
    vec[13] = '{A_START,    S_IDLE,  0, 0, 1, 2'b00, 0};
    vec[14] = '{A_START,    S_SERVE, 0, 0, 1, 2'b00, 0};
    vec[15] = '{A_START,    S_RALLY, 0, 0, 1, 2'b00, 0};
    vec[16] = '{A_RIGHT,    S_SERVE, 1, 0, 1, 2'b00, 1};
    vec[17] = '{A_START,    S_RALLY, 1, 0, 1, 2'b00, 0};

    // Reset state
    repeat (3) @(negedge clk_100MHz);
    check_outs("reset", S_IDLE, 0, 0, 0, 0);
    chk("reset_point_pulse", point_pulse, 0);
    reset_n = 1'b1;

    for (int i = 0; i <= 10; i++) run_vec(i);

    // Goal during holdoff is ignored; a sensor already high when the rally
    // begins yields no event.
    begin
      snap_t e;
      bit seen;
      e.sl = 2; e.sr = 2; e.ss = 0; e.win = 2'b00; e.st = S_HOLD;
      sb.push_back(e);
      @(negedge clk_100MHz);
      ir_left = 1'b1;
      seen = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
        @(negedge clk_100MHz);
        seen = point_pulse;
      end
      chk("lockout_pulse_seen", int'(seen), 1);
      ir_right = 1'b1;
      repeat (15) @(negedge clk_100MHz);
      chk("lockout_in_holdoff", state, S_HOLD);
      ir_left = 1'b0;
      repeat (60) @(negedge clk_100MHz);
      check_outs("lockout", S_SERVE, 2, 2, 0, 0);
      start_btn = 1'b1;
      repeat (30) @(negedge clk_100MHz);
      start_btn = 1'b0;
      repeat (50) @(negedge clk_100MHz);
      check_outs("prehigh", S_RALLY, 2, 2, 0, 0);
      ir_right = 1'b0;
      repeat (50) @(negedge clk_100MHz);
      check_outs("prehigh_rel", S_RALLY, 2, 2, 0, 0);
    end

    for (int i = 11; i <= 17; i++) run_vec(i);

    // Reset asserted across the window in which the goal event lands.
    @(negedge clk_100MHz);
    ir_right = 1'b1;
    repeat (5) @(negedge clk_100MHz);
    reset_n = 1'b0;
    repeat (25) @(negedge clk_100MHz);
    ir_right = 1'b0;
    reset_n = 1'b1;
    repeat (60) @(negedge clk_100MHz);
    check_outs("midreset", S_IDLE, 0, 0, 0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
